// File: rtl/sd_init_seq.sv
// SD card power-up sequencer: drives the command engine through CMD0/8/55/41/2/3/7/16.
// Optional SD_INIT_WIDEBUS_EN adds CMD55+ACMD6 after CMD7 to switch the card to a 4-bit bus.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | after reset, waiting for init_start
// S_CMD0   | GO_IDLE_STATE with 80 precount clocks, no response expected
// S_CMD8   | SEND_IF_COND, timeout marks a v1 card
// S_CMD55  | APP_CMD prefix for ACMD41
// S_ACMD41 | SD_SEND_OP_COND, polled until the card is ready
// S_CMD2   | ALL_SEND_CID
// S_CMD3   | SEND_RELATIVE_ADDR, latches rca
// S_CMD7   | SELECT_CARD
// S_CMD55W | APP_CMD prefix for ACMD6
// S_ACMD6  | SET_BUS_WIDTH to 4 bits
// S_CMD16  | SET_BLOCKLEN 512, byte-addressed cards only
// S_DONE   | card in transfer state, fast clock
// S_FAIL   | aborted, err_code valid
module sd_init_seq #(
  parameter logic [15:0] SLOW_DIV     = 16'd99,
  parameter logic [15:0] FAST_DIV     = 16'd1,
  parameter int          CMD_RETRIES  = 3,
  parameter logic [15:0] ACMD41_TRIES = 16'd1000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        init_start,
  output logic        init_busy,
  output logic        init_done,
  output logic        init_err,
  output logic [3:0]  err_code,
  output logic [1:0]  card_type,
  output logic [15:0] rca,
  output logic [15:0] clkdiv,
  output logic        cmd_start,
  output logic [15:0] cmd_precnt,
  output logic [5:0]  cmd_idx,
  output logic [31:0] cmd_arg,
  input  logic        cmd_busy,
  input  logic        cmd_done,
  input  logic        cmd_timeout,
  input  logic        cmd_syntaxe,
  input  logic [31:0] cmd_resp
);

  typedef enum logic [3:0] {
    S_IDLE, S_CMD0, S_CMD8, S_CMD55, S_ACMD41, S_CMD2, S_CMD3,
    S_CMD7, S_CMD55W, S_ACMD6, S_CMD16, S_DONE, S_FAIL
  } state_t;

  state_t      state;
  logic        wait_rsp;
  logic        v1;
  logic [1:0]  retry_cnt;
  logic [15:0] acmd_cnt;

  logic [5:0]  c_idx;
  logic [31:0] c_arg;
  logic [15:0] c_pre;
  logic [3:0]  c_err;
  state_t      after_bus;
  state_t      after_cmd7;
  state_t      nxt;
  logic        cmd_bad;
  logic        abort_now;
  logic        retry_now;
  logic        abort;

  always_comb begin
    c_idx = 6'd0;
    c_arg = 32'h0;
    c_pre = 16'd0;
    c_err = 4'd0;
    case (state)
      S_CMD0:   begin c_idx = 6'd0;  c_pre = 16'd80; c_err = 4'd1; end
      S_CMD8:   begin c_idx = 6'd8;  c_arg = 32'h0000_01AA; c_err = 4'd2; end
      S_CMD55:  begin c_idx = 6'd55; c_err = 4'd3; end
      S_ACMD41: begin
        c_idx = 6'd41;
        c_arg = v1 ? 32'h0010_0000 : 32'h4010_0000;
        c_err = 4'd3;
      end
      S_CMD2:   begin c_idx = 6'd2;  c_err = 4'd4; end
      S_CMD3:   begin c_idx = 6'd3;  c_err = 4'd5; end
      S_CMD7:   begin c_idx = 6'd7;  c_arg = {rca, 16'h0}; c_err = 4'd6; end
      S_CMD55W: begin c_idx = 6'd55; c_arg = {rca, 16'h0}; c_err = 4'd8; end
      S_ACMD6:  begin c_idx = 6'd6;  c_arg = 32'h0000_0002; c_err = 4'd8; end
      S_CMD16:  begin c_idx = 6'd16; c_arg = 32'd512; c_err = 4'd7; end
      default: ;
    endcase
  end

  // block-addressed (SDHC/XC) cards have a fixed 512-byte block, so CMD16 is skipped
  always_comb begin
    after_bus = (card_type == 2'd3) ? S_DONE : S_CMD16;
`ifdef SD_INIT_WIDEBUS_EN
    after_cmd7 = S_CMD55W;
`else
    after_cmd7 = after_bus;
`endif
  end

  always_comb begin
    nxt       = state;
    cmd_bad   = 1'b0;
    abort_now = 1'b0;
    case (state)
      S_CMD0:   if (cmd_syntaxe && !cmd_timeout) cmd_bad = 1'b1; else nxt = S_CMD8;
      S_CMD8: begin
        if (cmd_timeout)                   nxt = S_CMD55;
        else if (cmd_syntaxe)              cmd_bad = 1'b1;
        else if (cmd_resp[11:0] == 12'h1AA) nxt = S_CMD55;
        else                               abort_now = 1'b1;
      end
      S_CMD55:  if (cmd_timeout || cmd_syntaxe) cmd_bad = 1'b1; else nxt = S_ACMD41;
      S_ACMD41: begin
        if (cmd_timeout || cmd_syntaxe) cmd_bad = 1'b1;
        else if (cmd_resp[31])          nxt = S_CMD2;
        else if (acmd_cnt <= 16'd1)     abort_now = 1'b1;
        else                            nxt = S_CMD55;
      end
      S_CMD2:   if (cmd_timeout) cmd_bad = 1'b1; else nxt = S_CMD3;
      S_CMD3:   if (cmd_timeout || cmd_syntaxe || cmd_resp[31:16] == 16'h0) cmd_bad = 1'b1;
                else nxt = S_CMD7;
      S_CMD7:   if (cmd_timeout || cmd_syntaxe) cmd_bad = 1'b1; else nxt = after_cmd7;
      S_CMD55W: if (cmd_timeout || cmd_syntaxe) cmd_bad = 1'b1; else nxt = S_ACMD6;
      S_ACMD6:  if (cmd_timeout || cmd_syntaxe) cmd_bad = 1'b1; else nxt = after_bus;
      S_CMD16:  if (cmd_timeout || cmd_syntaxe) cmd_bad = 1'b1; else nxt = S_DONE;
      default: ;
    endcase
    retry_now = cmd_bad && (retry_cnt != 2'd0);
    abort     = abort_now || (cmd_bad && (retry_cnt == 2'd0));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      wait_rsp   <= 1'b0;
      v1         <= 1'b0;
      retry_cnt  <= 2'd0;
      acmd_cnt   <= 16'd0;
      init_busy  <= 1'b0;
      init_done  <= 1'b0;
      init_err   <= 1'b0;
      err_code   <= 4'd0;
      card_type  <= 2'd0;
      rca        <= 16'h0;
      clkdiv     <= SLOW_DIV;
      cmd_start  <= 1'b0;
      cmd_precnt <= 16'd0;
      cmd_idx    <= 6'd0;
      cmd_arg    <= 32'h0;
    end else begin
      cmd_start <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_FAIL: begin
          if (init_start && !cmd_done) begin
            state     <= S_CMD0;
            wait_rsp  <= 1'b0;
            retry_cnt <= 2'(CMD_RETRIES);
            v1        <= 1'b0;
            init_busy <= 1'b1;
            init_done <= 1'b0;
            init_err  <= 1'b0;
            err_code  <= 4'd0;
            card_type <= 2'd0;
            rca       <= 16'h0;
            clkdiv    <= SLOW_DIV;
          end
        end
        default: begin
          if (!wait_rsp) begin
            if (!cmd_busy) begin
              cmd_start  <= 1'b1;
              cmd_idx    <= c_idx;
              cmd_arg    <= c_arg;
              cmd_precnt <= c_pre;
              wait_rsp   <= 1'b1;
            end
          end else if (cmd_done) begin
            wait_rsp <= 1'b0;
            if (abort) begin
              state     <= S_FAIL;
              init_err  <= 1'b1;
              err_code  <= c_err;
              init_busy <= 1'b0;
              clkdiv    <= SLOW_DIV;
            end else if (retry_now) begin
              retry_cnt <= retry_cnt - 2'd1;
            end else begin
              state     <= nxt;
              retry_cnt <= 2'(CMD_RETRIES);
              case (state)
                S_CMD8: begin
                  v1       <= cmd_timeout;
                  acmd_cnt <= ACMD41_TRIES;
                end
                S_ACMD41: begin
                  if (cmd_resp[31])
                    card_type <= v1 ? 2'd1 : (cmd_resp[30] ? 2'd3 : 2'd2);
                  else
                    acmd_cnt <= acmd_cnt - 16'd1;
                end
                S_CMD3: rca <= cmd_resp[31:16];
                default: ;
              endcase
              if (nxt == S_DONE) begin
                init_done <= 1'b1;
                init_busy <= 1'b0;
                clkdiv    <= FAST_DIV;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_init_seq.sv
// Scoreboard bench for sd_init_seq: a behavioural command engine pops expected commands and replies.
module tb_sd_init_seq;

  localparam logic [15:0] SLOW = 16'd99;
  localparam logic [15:0] FAST = 16'd1;

  logic        clk = 1'b0;
  logic        rstn;
  logic        init_start;
  logic        init_busy, init_done, init_err;
  logic [3:0]  err_code;
  logic [1:0]  card_type;
  logic [15:0] rca, clkdiv, cmd_precnt;
  logic        cmd_start;
  logic [5:0]  cmd_idx;
  logic [31:0] cmd_arg;
  logic        cmd_busy, cmd_done, cmd_timeout, cmd_syntaxe;
  logic [31:0] cmd_resp;

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [15:0] pre;
    logic        tmo;
    logic        syn;
    logic [31:0] resp;
    logic        hang;
  } ent_t;

  ent_t sb[$];
  ent_t e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_starts = 0;
  logic hang_active;

  sd_init_seq #(.SLOW_DIV(SLOW), .FAST_DIV(FAST), .CMD_RETRIES(3), .ACMD41_TRIES(16'd4)) dut (
    .clk(clk), .rstn(rstn), .init_start(init_start),
    .init_busy(init_busy), .init_done(init_done), .init_err(init_err),
    .err_code(err_code), .card_type(card_type), .rca(rca), .clkdiv(clkdiv),
    .cmd_start(cmd_start), .cmd_precnt(cmd_precnt), .cmd_idx(cmd_idx), .cmd_arg(cmd_arg),
    .cmd_busy(cmd_busy), .cmd_done(cmd_done), .cmd_timeout(cmd_timeout),
    .cmd_syntaxe(cmd_syntaxe), .cmd_resp(cmd_resp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [15:0] pre,
                         input logic tmo, input logic [31:0] resp);
    sb.push_back('{idx, arg, pre, tmo, 1'b0, resp, 1'b0});
  endtask

  task automatic exp_hang(input logic [5:0] idx, input logic [31:0] arg);
    sb.push_back('{idx, arg, 16'd0, 1'b0, 1'b0, 32'h0, 1'b1});
  endtask

  task automatic exp_cmd0_cmd8(input logic v1_card);
    exp_cmd(6'd0, 32'h0, 16'd80, 1'b1, 32'h0);
    exp_cmd(6'd8, 32'h1AA, 16'd0, v1_card, v1_card ? 32'h0 : 32'h0000_01AA);
  endtask

  task automatic exp_pair(input logic [31:0] arg41, input logic [31:0] resp41);
    exp_cmd(6'd55, 32'h0, 16'd0, 1'b0, 32'h0000_0120);
    exp_cmd(6'd41, arg41, 16'd0, 1'b0, resp41);
  endtask

  task automatic exp_after_cmd7(input logic [15:0] r, input logic [1:0] ct);
`ifdef SD_INIT_WIDEBUS_EN
    exp_cmd(6'd55, {r, 16'h0}, 16'd0, 1'b0, 32'h0000_0120);
    exp_cmd(6'd6, 32'h2, 16'd0, 1'b0, 32'h0000_0920);
`endif
    if (ct != 2'd3) exp_cmd(6'd16, 32'd512, 16'd0, 1'b0, 32'h0000_0900);
  endtask

  task automatic exp_id(input logic [15:0] r);
    exp_cmd(6'd2, 32'h0, 16'd0, 1'b0, 32'h1234_5678);
    exp_cmd(6'd3, 32'h0, 16'd0, 1'b0, {r, 16'h0500});
  endtask

  // pulses init_start, waits for the sequence to settle, then idles to catch stray starts
  task automatic run_init(input string tag);
    @(negedge clk) init_start = 1'b1;
    @(negedge clk) init_start = 1'b0;
    for (int i = 0; i < 3000 && init_busy; i++) @(negedge clk);
    check({tag, "_finished"}, init_busy, 1'b0);
    repeat (30) @(negedge clk);
    check({tag, "_cmds_left"}, sb.size(), 0);
  endtask

  // command engine model
  initial begin
    cmd_busy = 1'b0; cmd_done = 1'b0; cmd_timeout = 1'b0; cmd_syntaxe = 1'b0;
    cmd_resp = 32'h0; hang_active = 1'b0;
    forever begin
      @(negedge clk);
      if (rstn === 1'b1 && cmd_start) begin
        n_starts++;
        check("start_while_busy", cmd_busy, 1'b0);
        check("cmd_expected", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("cmd_idx", cmd_idx, e.idx);
          check("cmd_arg", cmd_arg, e.arg);
          check("cmd_precnt", cmd_precnt, e.pre);
          cmd_busy = 1'b1;
          if (e.hang) begin
            hang_active = 1'b1;
            for (int i = 0; i < 500 && rstn; i++) @(negedge clk);
            cmd_busy = 1'b0;
            hang_active = 1'b0;
          end else begin
            repeat (4) @(negedge clk);
            cmd_timeout = e.tmo; cmd_syntaxe = e.syn; cmd_resp = e.resp;
            cmd_done = 1'b1; cmd_busy = 1'b0;
            @(negedge clk);
            cmd_done = 1'b0; cmd_timeout = 1'b0; cmd_syntaxe = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n0;
    rstn = 1'b0; init_start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_clkdiv", clkdiv, SLOW);
    check("rst_busy", init_busy, 1'b0);
    check("rst_done", init_done, 1'b0);
    check("rst_err", init_err, 1'b0);
    check("rst_start", cmd_start, 1'b0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // SDHC: three busy ACMD41 replies, then ready with CCS
    exp_cmd0_cmd8(1'b0);
    for (int i = 0; i < 3; i++) exp_pair(32'h4010_0000, 32'h00FF_8000);
    exp_pair(32'h4010_0000, 32'hC0FF_8000);
    exp_id(16'hAAAA);
    exp_cmd(6'd7, 32'hAAAA_0000, 16'd0, 1'b0, 32'h0000_0700);
    exp_after_cmd7(16'hAAAA, 2'd3);
    run_init("sdhc");
    check("sdhc_done", init_done, 1'b1);
    check("sdhc_err", init_err, 1'b0);
    check("sdhc_type", card_type, 2'd3);
    check("sdhc_rca", rca, 16'hAAAA);
    check("sdhc_clkdiv", clkdiv, FAST);

    // SDv1, with a stray init_start mid-sequence that must be ignored
    exp_cmd0_cmd8(1'b1);
    exp_pair(32'h0010_0000, 32'h80FF_8000);
    exp_id(16'h1234);
    exp_cmd(6'd7, 32'h1234_0000, 16'd0, 1'b0, 32'h0000_0700);
    exp_after_cmd7(16'h1234, 2'd1);
    @(negedge clk) init_start = 1'b1;
    @(negedge clk) init_start = 1'b0;
    repeat (40) @(negedge clk);
    @(negedge clk) init_start = 1'b1;
    @(negedge clk) init_start = 1'b0;
    for (int i = 0; i < 3000 && init_busy; i++) @(negedge clk);
    check("sdv1_finished", init_busy, 1'b0);
    repeat (30) @(negedge clk);
    check("sdv1_cmds_left", sb.size(), 0);
    check("sdv1_done", init_done, 1'b1);
    check("sdv1_type", card_type, 2'd1);
    check("sdv1_rca", rca, 16'h1234);

    // CMD8 pattern mismatch aborts immediately
    n0 = n_starts;
    exp_cmd(6'd0, 32'h0, 16'd80, 1'b1, 32'h0);
    exp_cmd(6'd8, 32'h1AA, 16'd0, 1'b0, 32'h0000_01A5);
    run_init("cmd8bad");
    check("cmd8bad_err", init_err, 1'b1);
    check("cmd8bad_code", err_code, 4'd2);
    check("cmd8bad_done", init_done, 1'b0);
    check("cmd8bad_clkdiv", clkdiv, SLOW);
    check("cmd8bad_starts", n_starts - n0, 2);

    // ACMD41 never ready: exactly four pairs with ACMD41_TRIES=4
    n0 = n_starts;
    exp_cmd0_cmd8(1'b0);
    for (int i = 0; i < 4; i++) exp_pair(32'h4010_0000, 32'h00FF_8000);
    run_init("acmd41");
    check("acmd41_err", init_err, 1'b1);
    check("acmd41_code", err_code, 4'd3);
    check("acmd41_starts", n_starts - n0, 10);

    // CMD7: three timeouts, fourth attempt succeeds (SDv2 SDSC)
    exp_cmd0_cmd8(1'b0);
    exp_pair(32'h4010_0000, 32'h80FF_8000);
    exp_id(16'h0042);
    for (int i = 0; i < 3; i++) exp_cmd(6'd7, 32'h0042_0000, 16'd0, 1'b1, 32'h0);
    exp_cmd(6'd7, 32'h0042_0000, 16'd0, 1'b0, 32'h0000_0700);
    exp_after_cmd7(16'h0042, 2'd2);
    run_init("cmd7retry");
    check("cmd7retry_done", init_done, 1'b1);
    check("cmd7retry_type", card_type, 2'd2);

    // CMD7: four timeouts exhaust the retries
    exp_cmd0_cmd8(1'b0);
    exp_pair(32'h4010_0000, 32'h80FF_8000);
    exp_id(16'h0042);
    for (int i = 0; i < 4; i++) exp_cmd(6'd7, 32'h0042_0000, 16'd0, 1'b1, 32'h0);
    run_init("cmd7fail");
    check("cmd7fail_err", init_err, 1'b1);
    check("cmd7fail_code", err_code, 4'd6);
    check("cmd7fail_clkdiv", clkdiv, SLOW);

    // reset while CMD3 is outstanding, then a clean restart
    exp_cmd0_cmd8(1'b0);
    exp_pair(32'h4010_0000, 32'hC0FF_8000);
    exp_cmd(6'd2, 32'h0, 16'd0, 1'b0, 32'h1234_5678);
    exp_hang(6'd3, 32'h0);
    @(negedge clk) init_start = 1'b1;
    @(negedge clk) init_start = 1'b0;
    for (int i = 0; i < 3000 && !hang_active; i++) @(negedge clk);
    check("rstmid_reached_cmd3", hang_active, 1'b1);
    @(negedge clk) rstn = 1'b0;
    #1;
    check("rstmid_busy", init_busy, 1'b0);
    check("rstmid_type", card_type, 2'd0);
    check("rstmid_clkdiv", clkdiv, SLOW);
    check("rstmid_err", init_err, 1'b0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    exp_cmd0_cmd8(1'b0);
    exp_pair(32'h4010_0000, 32'hC0FF_8000);
    exp_id(16'hAAAA);
    exp_cmd(6'd7, 32'hAAAA_0000, 16'd0, 1'b0, 32'h0000_0700);
    exp_after_cmd7(16'hAAAA, 2'd3);
    run_init("restart");
    check("restart_done", init_done, 1'b1);
    check("restart_rca", rca, 16'hAAAA);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
